// File: rtl/sha384_arbiter.sv
// Round-robin, message-granular arbiter feeding NREQ byte streams into one SHA-384 core,
// with message tagging and a one-cycle result demux back to the requesters.
module sha384_arbiter #(
  parameter int NREQ = 4,
  parameter int SEQW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     s_tvalid,
  output logic [NREQ-1:0]     s_tready,
  input  logic [NREQ-1:0]     s_tlast,
  input  logic [8*NREQ-1:0]   s_tdata,
  input  logic                c_tready,
  output logic                c_tvalid,
  output logic                c_tlast,
  output logic [7:0]          c_tdata,
  output logic [31:0]         c_tid,
  input  logic                c_ovalid,
  input  logic [31:0]         c_oid,
  input  logic [60:0]         c_olen,
  output logic [NREQ-1:0]     done,
  output logic [SEQW-1:0]     done_seq,
  output logic [60:0]         done_len,
  output logic                busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, XFER} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   rr_pick;
  logic            rr_found;
  logic            seq_inc;
  logic [SEQW-1:0] seq_q [NREQ];

  logic [NREQ-1:0] done_q, done_d;
  logic [SEQW-1:0] done_seq_q, done_seq_d;
  logic [60:0]     done_len_q, done_len_d;

  logic            unused_oid;
  assign unused_oid = ^c_oid;

  // First valid requester searching upward from the one after the last grantee.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_q;
    for (int i = 1; i <= NREQ; i++) begin
      if (!rr_found && s_tvalid[(int'(last_q) + i) % NREQ]) begin
        rr_found = 1'b1;
        rr_pick  = GW'((int'(last_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    seq_inc  = 1'b0;
    s_tready = '0;
    c_tvalid = 1'b0;
    c_tlast  = 1'b0;
    c_tdata  = '0;
    c_tid    = '0;
    case (state_q)
      ARB: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = XFER;
        end
      end
      XFER: begin
        // Stream outputs are forced quiet while reset is asserted.
        if (!rst) begin
          s_tready[grant_q] = c_tready;
          c_tvalid          = s_tvalid[grant_q];
          c_tlast           = s_tlast[grant_q];
          c_tdata           = s_tdata[{grant_q, 3'b000} +: 8];
          c_tid             = 32'({seq_q[grant_q], 8'(grant_q)});
        end
        if (s_tvalid[grant_q] && c_tready && s_tlast[grant_q]) begin
          seq_inc = 1'b1;
          last_d  = grant_q;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    done_seq_d = done_seq_q;
    done_len_d = done_len_q;
    done_d     = '0;
    for (int r = 0; r < NREQ; r++) begin
      done_d[r] = c_ovalid && (c_oid[7:0] == 8'(r));
    end
    if (c_ovalid) begin
      done_seq_d = c_oid[8 +: SEQW];
      done_len_d = c_olen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      grant_q    <= '0;
      last_q     <= GW'(NREQ - 1);
      for (int r = 0; r < NREQ; r++) seq_q[r] <= '0;
      done_q     <= '0;
      done_seq_q <= '0;
      done_len_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      if (seq_inc) seq_q[grant_q] <= seq_q[grant_q] + SEQW'(1);
      done_q     <= done_d;
      done_seq_q <= done_seq_d;
      done_len_q <= done_len_d;
    end
  end

  assign done     = done_q;
  assign done_seq = done_seq_q;
  assign done_len = done_len_q;
  assign busy     = (state_q == XFER);

endmodule

// File: tb/tb_sha384_arbiter.sv
// Scoreboard bench: a message-level round-robin model predicts the core-side byte stream,
// a separate monitor checks the stream and the result demux every cycle.
module tb_sha384_arbiter;

  localparam int NREQ = 4;
  localparam int SEQW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   s_tvalid, s_tready, s_tlast;
  logic [8*NREQ-1:0] s_tdata;
  logic              c_tready, c_tvalid, c_tlast;
  logic [7:0]        c_tdata;
  logic [31:0]       c_tid;
  logic              c_ovalid;
  logic [31:0]       c_oid;
  logic [60:0]       c_olen;
  logic [NREQ-1:0]   done;
  logic [SEQW-1:0]   done_seq;
  logic [60:0]       done_len;
  logic              busy;

  always #5 clk = ~clk;

  sha384_arbiter #(.NREQ(NREQ), .SEQW(SEQW)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .c_tready(c_tready), .c_tvalid(c_tvalid), .c_tlast(c_tlast), .c_tdata(c_tdata),
    .c_tid(c_tid), .c_ovalid(c_ovalid), .c_oid(c_oid), .c_olen(c_olen),
    .done(done), .done_seq(done_seq), .done_len(done_len), .busy(busy)
  );

  typedef struct packed {logic bub; logic last; logic [7:0] data;} ditem_t;
  typedef struct packed {logic [31:0] tid; logic last; logic [7:0] data;} exp_t;
  typedef struct packed {logic [31:0] tid; logic [60:0] len;} res_t;

  ditem_t      drv_q[NREQ][$];
  logic [8:0]  mdl_q[NREQ][$];
  exp_t        exp_q[$];
  res_t        res_q[$];
  logic [31:0] tid_log[$];

  int total = 0;
  int bad   = 0;
  int m_last;
  int m_seq[NREQ];
  logic [NREQ-1:0] hs;
  int stall;
  bit stall_mode, rand_ready, bad_ov_en;
  int bytes_seen, bytes_exp;
  logic [NREQ-1:0] cap_done_or;
  int              cap_cnt;
  logic [SEQW-1:0] cap_seq;
  logic [60:0]     cap_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic last);
    ditem_t it;
    it.bub = 1'b0; it.last = last; it.data = d;
    drv_q[r].push_back(it);
    mdl_q[r].push_back({last, d});
    bytes_exp++;
  endtask

  task automatic add_msg(input int r, input int len, input int gap_at, input int gap_len);
    ditem_t it;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at && i > 0) begin
        it.bub = 1'b1; it.last = 1'b0; it.data = 8'h00;
        repeat (gap_len) drv_q[r].push_back(it);
      end
      add_byte(r, 8'($urandom), i == len - 1);
    end
  endtask

  // Message-level reference: each grant goes to the next requester (after the previous
  // grantee) that still has a message queued; tag = {sequence, index}.
  task automatic schedule();
    int g;
    logic [8:0] b;
    exp_t e;
    forever begin
      g = -1;
      for (int i = 1; i <= NREQ; i++)
        if (g < 0 && mdl_q[(m_last + i) % NREQ].size() > 0) g = (m_last + i) % NREQ;
      if (g < 0) break;
      do begin
        b = mdl_q[g].pop_front();
        e.tid  = 32'({SEQW'(m_seq[g]), 8'(g)});
        e.last = b[8];
        e.data = b[7:0];
        exp_q.push_back(e);
      end while (!b[8]);
      m_seq[g] = (m_seq[g] + 1) % (1 << SEQW);
      m_last   = g;
    end
  endtask

  task automatic step();
    ditem_t it;
    res_t   rs;
    logic [31:0] id;
    @(negedge clk);
    for (int r = 0; r < NREQ; r++) begin
      if (drv_q[r].size() > 0) begin
        if (drv_q[r][0].bub) void'(drv_q[r].pop_front());
        else if (hs[r]) begin
          it = drv_q[r].pop_front();
          if (it.last && stall_mode) stall = 20;
        end
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (drv_q[r].size() > 0 && !drv_q[r][0].bub) begin
        s_tvalid[r] = 1'b1;
        s_tlast[r]  = drv_q[r][0].last;
        s_tdata[8*r +: 8] = drv_q[r][0].data;
      end else begin
        s_tvalid[r] = 1'b0;
        s_tlast[r]  = 1'($urandom);
        s_tdata[8*r +: 8] = 8'($urandom);
      end
    end
    if (stall > 0) begin
      c_tready = 1'b0;
      stall--;
    end else if (rand_ready) c_tready = ($urandom % 4) != 0;
    else c_tready = 1'b1;
    c_ovalid = 1'b0;
    if (res_q.size() > 0 && ($urandom % 3) != 0) begin
      rs = res_q.pop_front();
      c_ovalid = 1'b1; c_oid = rs.tid; c_olen = rs.len;
    end else if (bad_ov_en && ($urandom % 6) == 0) begin
      id = $urandom;
      id[7:0] = 8'(NREQ + $urandom_range(0, 255 - NREQ));
      c_ovalid = 1'b1; c_oid = id; c_olen = 61'({$urandom, $urandom});
    end
    #1;
    hs = rst ? '0 : (s_tvalid & s_tready);
  endtask

  function automatic int pending();
    int n = exp_q.size() + res_q.size();
    for (int r = 0; r < NREQ; r++) n += drv_q[r].size();
    return n;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_idle"}, 64'(pending()), 64'd0);
    check({name, "_bytes"}, 64'(bytes_seen), 64'(bytes_exp));
    repeat (3) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      drv_q[r].delete();
      mdl_q[r].delete();
      m_seq[r] = 0;
    end
    exp_q.delete();
    res_q.delete();
    hs = '0; stall = 0; m_last = NREQ - 1;
    s_tvalid = '0; c_ovalid = 1'b0; c_tready = 1'b1;
    bytes_seen = 0; bytes_exp = 0;
    #1;
    check("rst_comb_s_tready", 64'(s_tready), 64'd0);
    check("rst_comb_c_tvalid", 64'(c_tvalid), 64'd0);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    rst = 1'b0;
  endtask

  // Monitor: result demux and core-side stream, checked every cycle.
  initial begin : monitor
    logic prev_ov, prev_rst;
    logic [31:0] prev_id;
    logic [60:0] prev_len;
    logic [SEQW-1:0] m_dseq;
    logic [60:0] m_dlen;
    logic [NREQ-1:0] ed;
    exp_t e;
    int msg_len;
    prev_ov = 1'b0; prev_rst = 1'b1; prev_id = '0; prev_len = '0;
    m_dseq = '0; m_dlen = '0; msg_len = 0;
    forever begin
      @(negedge clk);
      #2;
      if (prev_rst) begin
        check("done_after_rst", 64'(done), 64'd0);
        check("done_seq_after_rst", 64'(done_seq), 64'd0);
        check("done_len_after_rst", 64'(done_len), 64'd0);
        m_dseq = '0; m_dlen = '0;
      end else if (prev_ov) begin
        ed = (prev_id[7:0] < 8'(NREQ)) ? (NREQ'(1) << prev_id[7:0]) : '0;
        m_dseq = prev_id[8 +: SEQW];
        m_dlen = prev_len;
        check("done_pulse", 64'(done), 64'(ed));
        check("done_seq", 64'(done_seq), 64'(m_dseq));
        check("done_len", 64'(done_len), 64'(m_dlen));
        cap_done_or |= done;
        if (done != '0) cap_cnt++;
        cap_seq = done_seq;
        cap_len = done_len;
      end else begin
        check("done_idle", 64'(done), 64'd0);
        check("done_seq_hold", 64'(done_seq), 64'(m_dseq));
        check("done_len_hold", 64'(done_len), 64'(m_dlen));
      end
      prev_rst = rst; prev_ov = c_ovalid; prev_id = c_oid; prev_len = c_olen;

      if (rst) begin
        check("rst_s_tready_q", 64'(s_tready), 64'd0);
        check("rst_c_tvalid_q", 64'(c_tvalid), 64'd0);
        check("rst_c_tid_q", 64'(c_tid), 64'd0);
        msg_len = 0;
      end else begin
        if (!busy) check("arb_quiet", 64'({s_tready, c_tvalid}), 64'd0);
        if (!c_tready) check("stall_no_ready", 64'(s_tready), 64'd0);
        check("ready_onehot0", 64'($countones(s_tready) <= 1), 64'd1);
        if (c_tvalid && c_tready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte: got tid %0h data %0h expected none", c_tid, c_tdata);
          end else begin
            e = exp_q.pop_front();
            check("byte_tid", 64'(c_tid), 64'(e.tid));
            check("byte_data", 64'(c_tdata), 64'(e.data));
            check("byte_last", 64'(c_tlast), 64'(e.last));
          end
          if (msg_len == 0) tid_log.push_back(c_tid);
          bytes_seen++;
          msg_len++;
          if (c_tlast) begin
            res_q.push_back('{tid: c_tid, len: 61'(msg_len)});
            msg_len = 0;
          end
        end
      end
    end
  end

  initial begin : stim
    int exp_tids[8] = '{32'h000, 32'h001, 32'h002, 32'h003, 32'h100, 32'h101, 32'h102, 32'h103};
    int n, target;
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    c_tready = 1'b1; c_ovalid = 1'b0; c_oid = '0; c_olen = '0;
    stall_mode = 0; rand_ready = 0; bad_ov_en = 0;
    cap_done_or = '0; cap_cnt = 0; cap_seq = '0; cap_len = '0;
    repeat (2) @(negedge clk);
    do_reset();
    check("init_busy", 64'(busy), 64'd0);

    // All requesters at once, two 3-byte messages each.
    tid_log.delete();
    for (int k = 0; k < 2; k++) for (int r = 0; r < NREQ; r++) add_msg(r, 3, 0, 0);
    schedule();
    run_until_idle("rr_round", 200);
    check("rr_msg_count", 64'(tid_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < tid_log.size(); i++) check("rr_tid_order", 64'(tid_log[i]), 64'(exp_tids[i]));

    // "abc" from requester 2 alone.
    do_reset();
    cap_done_or = '0; cap_cnt = 0;
    add_byte(2, 8'h61, 1'b0); add_byte(2, 8'h62, 1'b0); add_byte(2, 8'h63, 1'b1);
    schedule();
    run_until_idle("abc", 100);
    check("abc_done_bits", 64'(cap_done_or), 64'b0100);
    check("abc_done_count", 64'(cap_cnt), 64'd1);
    check("abc_done_seq", 64'(cap_seq), 64'd0);
    check("abc_done_len", 64'(cap_len), 64'd3);

    // Requester 1 goes idle mid-message while requester 0 waits.
    add_msg(0, 2, 0, 0);
    schedule();
    run_until_idle("prep_r0", 100);
    tid_log.delete();
    add_msg(1, 8, 3, 5);
    add_msg(0, 3, 0, 0);
    schedule();
    run_until_idle("hold_grant", 200);
    check("hold_msg_count", 64'(tid_log.size()), 64'd2);
    if (tid_log.size() == 2) begin
      check("hold_first_r1", 64'(tid_log[0]), 64'h001);
      check("hold_then_r0", 64'(tid_log[1]), 64'h100);
    end

    // Core stalls 20 cycles after each message end.
    stall_mode = 1;
    for (int r = 1; r < NREQ; r++) begin add_msg(r, 4, 0, 0); add_msg(r, 4, 2, 1); end
    schedule();
    run_until_idle("core_stall", 600);
    stall_mode = 0;

    // Randomized traffic with back-pressure and stray results.
    rand_ready = 1; bad_ov_en = 1;
    repeat (30) begin
      for (int r = 0; r < NREQ; r++) begin
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) add_msg(r, $urandom_range(1, 6), $urandom_range(0, 5), $urandom_range(0, 3));
      end
      schedule();
      run_until_idle("random", 1500);
    end
    rand_ready = 0; bad_ov_en = 0;

    // Sequence counter wrap on requester 0.
    do_reset();
    tid_log.delete();
    for (int k = 0; k < (1 << SEQW) + 2; k++) add_msg(0, 1, 0, 0);
    schedule();
    run_until_idle("seq_wrap", 4000);
    check("wrap_count", 64'(tid_log.size()), 64'((1 << SEQW) + 2));
    if (tid_log.size() == (1 << SEQW) + 2) begin
      check("wrap_top", 64'(tid_log[(1 << SEQW) - 1]), 64'h0000_ff00);
      check("wrap_zero", 64'(tid_log[1 << SEQW]), 64'h0000_0000);
      check("wrap_one", 64'(tid_log[(1 << SEQW) + 1]), 64'h0000_0100);
    end

    // Reset in the middle of a requester-3 message.
    add_msg(3, 3, 0, 0);
    schedule();
    run_until_idle("pre_abort", 100);
    add_msg(3, 12, 0, 0);
    schedule();
    target = bytes_seen + 4;
    n = 0;
    while (bytes_seen < target && n < 100) begin step(); n++; end
    check("abort_reached", 64'(bytes_seen >= target), 64'd1);
    check("abort_busy_before", 64'(busy), 64'd1);
    do_reset();
    tid_log.delete();
    add_msg(0, 2, 0, 0);
    add_msg(3, 2, 0, 0);
    schedule();
    run_until_idle("post_abort", 100);
    check("post_abort_count", 64'(tid_log.size()), 64'd2);
    if (tid_log.size() == 2) begin
      check("post_abort_r0", 64'(tid_log[0]), 64'h000);
      check("post_abort_r3", 64'(tid_log[1]), 64'h003);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
